// File: rtl/reaction_timer_ctrl.sv
// Reaction timer trial sequencer: random delay, stimulus LED, reaction measurement.
// Optional early-press detection during the delay: REACTION_EARLY_DETECT_EN.
module reaction_timer_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int MIN_DELAY_MS = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        rand_done_tick,
  input  logic [13:0] rand_num,
  output logic        rand_start,
  output logic        led,
  output logic        busy,
  output logic [9:0]  result_ms,
  output logic        result_valid,
  output logic        early,
  output logic        timeout
);

  localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RAND = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [12:0]  cnt_q, cnt_d;
  logic [12:0]  delay_q, delay_d;
  logic [9:0]   res_q, res_d;
  logic         valid_q, valid_d;
  logic         tmo_q, tmo_d;
  logic         early_q, early_d;
  logic         rs_q, rs_d;
  logic         led_q, led_d;
  logic         busy_q, busy_d;
  logic         ms_tick;
  logic         unused_rand;

  assign unused_rand = ^rand_num[13:12];
  assign ms_tick = (presc_q == PW'(TICKS_PER_MS - 1));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    res_d   = res_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    early_d = early_q;
    rs_d    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      res_d   = '0;
      valid_d = 1'b0;
      tmo_d   = 1'b0;
      early_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_RAND;
            rs_d    = 1'b1;
            res_d   = '0;
            valid_d = 1'b0;
            tmo_d   = 1'b0;
            early_d = 1'b0;
          end
        end
        S_RAND: begin
          if (rand_done_tick) begin
            state_d = S_WAIT;
            delay_d = 13'(MIN_DELAY_MS) + {1'b0, rand_num[11:0]};
            presc_d = '0;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
`ifdef REACTION_EARLY_DETECT_EN
          if (stop) begin
            state_d = S_DONE;
            early_d = 1'b1;
            res_d   = '0;
            valid_d = 1'b0;
          end else
`endif
          if (cnt_q == delay_q) begin
            state_d = S_MEAS;
            presc_d = '0;
            cnt_d   = '0;
          end else if (ms_tick) begin
            presc_d = '0;
            cnt_d   = cnt_q + 13'd1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_MEAS: begin
          // stop reports the count held before any same-cycle tick
          if (stop) begin
            state_d = S_DONE;
            res_d   = cnt_q[9:0];
            valid_d = 1'b1;
          end else if (ms_tick) begin
            presc_d = '0;
            if (cnt_q == 13'd999) begin
              state_d = S_DONE;
              res_d   = 10'd1000;
              tmo_d   = 1'b1;
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 13'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    led_d  = (state_d == S_MEAS);
    busy_d = (state_d == S_RAND) || (state_d == S_WAIT) ||
             (state_d == S_MEAS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      delay_q <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      early_q <= 1'b0;
      rs_q    <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      early_q <= early_d;
      rs_q    <= rs_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign rand_start   = rs_q;
  assign led          = led_q;
  assign busy         = busy_q;
  assign result_ms    = res_q;
  assign result_valid = valid_q;
  assign timeout      = tmo_q;
`ifdef REACTION_EARLY_DETECT_EN
  assign early = early_q;
`else
  logic unused_early;
  assign unused_early = early_q;
  assign early = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed scoreboard bench for reaction_timer_ctrl.
// TICKS_PER_MS=4, MIN_DELAY_MS=2.
module tb_reaction_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        rand_done_tick = 1'b0;
  logic [13:0] rand_num = '0;
  logic        rand_start;
  logic        led;
  logic        busy;
  logic [9:0]  result_ms;
  logic        result_valid;
  logic        early;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  reaction_timer_ctrl #(.TICKS_PER_MS(4), .MIN_DELAY_MS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .clear(clear), .rand_done_tick(rand_done_tick),
    .rand_num(rand_num), .rand_start(rand_start), .led(led),
    .busy(busy), .result_ms(result_ms),
    .result_valid(result_valid), .early(early),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {rand_start, led, busy, result_valid, early, timeout, result_ms}
  function automatic logic [31:0] outs();
    return {16'd0, rand_start, led, busy, result_valid,
            early, timeout, result_ms};
  endfunction

  function automatic logic [31:0] mk(input logic rs, input logic l,
      input logic b, input logic v, input logic e, input logic t,
      input int ms);
    return {16'd0, rs, l, b, v, e, t, 10'(ms)};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0h required=entry", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (led !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic give_rand(input int v);
    rand_num = 14'(v);
    rand_done_tick = 1'b1;
    step();
    rand_done_tick = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int led_seen;

    step();
    step();
    reset = 1'b0;
    push("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
    chk(outs());

    // normal trial
    push("start_rand", mk(1, 0, 1, 0, 0, 0, 0));
    pulse_start();
    chk(outs());
    push("rand_start_once", mk(0, 0, 1, 0, 0, 0, 0));
    step();
    chk(outs());
    give_rand(5);
    push("wait_7ms", 32'd1);
    wait_led(n);
    chk(32'((n >= 27) && (n <= 29)));
    push("meas_led", mk(0, 1, 1, 0, 0, 0, 0));
    chk(outs());
    repeat (40) step();
    push("stop_10ms", mk(0, 0, 0, 1, 0, 0, 10));
    pulse_stop();
    chk(outs());
    push("done_hold", mk(0, 0, 0, 1, 0, 0, 10));
    repeat (5) step();
    chk(outs());

    // timeout trial, start from DONE, start ignored in WAIT
    push("restart_clears", mk(1, 0, 1, 0, 0, 0, 0));
    pulse_start();
    chk(outs());
    step();
    give_rand(0);
    step();
    push("start_in_wait", mk(0, 0, 1, 0, 0, 0, 0));
    pulse_start();
    chk(outs());
    push("no_second_rs", mk(0, 0, 1, 0, 0, 0, 0));
    step();
    chk(outs());
    push("led_rise_t", 32'd1);
    wait_led(n);
    chk(32'(led));
    n = 0;
    while (led === 1'b1 && n < 5000) begin
      n++;
      step();
    end
    push("led_4000", 32'd1);
    chk(32'((n >= 3999) && (n <= 4001)));
    push("timeout_res", mk(0, 0, 0, 1, 0, 1, 1000));
    chk(outs());

    // stop on the 1000th tick wins
    pulse_start();
    step();
    give_rand(0);
    wait_led(n);
    repeat (3999) step();
    push("stop_at_1000", mk(0, 0, 0, 1, 0, 0, 999));
    pulse_stop();
    chk(outs());

    // stop 3 cycles into WAIT
    pulse_start();
    step();
    give_rand(5);
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
`ifdef REACTION_EARLY_DETECT_EN
    push("early_done", mk(0, 0, 0, 0, 1, 0, 0));
    chk(outs());
    led_seen = 0;
    repeat (60) begin
      step();
      if (led === 1'b1) led_seen = 1;
    end
    push("early_no_led", 32'd0);
    chk(32'(led_seen));
`else
    push("stop_ign_wait", mk(0, 0, 1, 0, 0, 0, 0));
    chk(outs());
    push("led_after_ign", 32'd1);
    wait_led(n);
    chk(32'(led));
    repeat (12) step();
    push("stop_3ms", mk(0, 0, 0, 1, 0, 0, 3));
    pulse_stop();
    chk(outs());
`endif

    // clear beats stop in MEASURE
    pulse_start();
    step();
    give_rand(1);
    wait_led(n);
    repeat (9) step();
    clear = 1'b1;
    stop = 1'b1;
    push("clear_stop", mk(0, 0, 0, 0, 0, 0, 0));
    step();
    clear = 1'b0;
    stop = 1'b0;
    chk(outs());
    step();
    push("idle_after_clr", mk(0, 0, 0, 0, 0, 0, 0));
    chk(outs());

    // reset mid-MEASURE
    pulse_start();
    step();
    give_rand(0);
    wait_led(n);
    repeat (5) step();
    reset = 1'b1;
    push("reset_meas", mk(0, 0, 0, 0, 0, 0, 0));
    step();
    reset = 1'b0;
    chk(outs());
    push("idle_after_rst", mk(0, 0, 0, 0, 0, 0, 0));
    repeat (3) step();
    chk(outs());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
